branch_resolve_ctrl: RTL

- Sequences ID-stage branch resolution around the branch comparator.
- Stalls ID while branch operands are not yet forwardable, then qualifies the comparator's take flag with the branch code.
- Drives NPC select and the branch target.
- Freezes the decision while the pipeline is held, so late forwarding or writeback cannot flip a resolved branch.

---
 rtl/branch_resolve_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution sequencer: operand-wait stall, take qualification and hold freeze.
// Define BRANCH_STATS_EN to add saturating branch / taken / stall counters.
module branch_resolve_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [3:0]        branch,
  input  logic              opnd_ready,
  input  logic              cmp_take,
  input  logic              pipe_hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc4_id,
  input  logic [15:0]       imm16,
  output logic              stall_br,
  output logic              npc_sel_br,
  output logic [ADDR_W-1:0] br_target,
  output logic              wait_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_br,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  localparam logic [7:0] WaitLimit = 8'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              take_q, take_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              err_q, err_d;

  logic              is_br;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] tgt_calc;
  logic [7:0]        wait_inc;
  logic              stall_c;
  logic              npc_c;
  logic [ADDR_W-1:0] tgt_c;

  assign is_br    = br_valid && (branch >= 4'd1) && (branch <= 4'd6);
  assign offset   = ADDR_W'(signed'({imm16, 2'b00}));
  assign tgt_calc = pc4_id + offset;
  assign wait_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    take_d     = take_q;
    tgt_d      = tgt_q;
    err_d      = err_q;
    stall_c    = 1'b0;
    npc_c      = 1'b0;
    tgt_c      = '0;

    if (flush) begin
      // Flush kills the branch outright; the sticky error survives.
      state_d    = StIdle;
      wait_cnt_d = '0;
      take_d     = 1'b0;
      tgt_d      = '0;
    end else begin
      unique case (state_q)
        StIdle, StWait: begin
          if (!is_br) begin
            state_d    = StIdle;
            wait_cnt_d = '0;
          end else if (!opnd_ready) begin
            stall_c    = 1'b1;
            state_d    = StWait;
            wait_cnt_d = (state_q == StIdle) ? 8'd1 : wait_inc;
            if (wait_cnt_d == WaitLimit) begin
              err_d = 1'b1;
            end
          end else begin
            npc_c      = cmp_take;
            tgt_c      = tgt_calc;
            wait_cnt_d = '0;
            if (pipe_hold) begin
              // Freeze the decision so late forwarding cannot flip it.
              take_d  = cmp_take;
              tgt_d   = tgt_calc;
              state_d = StHold;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StHold: begin
          npc_c = take_q;
          tgt_c = tgt_q;
          if (!pipe_hold) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      take_q     <= 1'b0;
      tgt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      take_q     <= take_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
    end
  end

  // Outputs are combinational from inputs in IDLE, so force them low while reset is asserted.
  assign stall_br   = stall_c & ~reset;
  assign npc_sel_br = npc_c & ~reset;
  assign br_target  = reset ? '0 : tgt_c;
  assign wait_err   = err_q;

`ifdef BRANCH_STATS_EN
  logic        resolved;
  logic [31:0] st_br_q, st_taken_q, st_stall_q;

  // A branch counts when it leaves for IDLE with a decision: direct resolve or hold release.
  assign resolved = !flush &&
                    (((state_q == StIdle) || (state_q == StWait)) && is_br && opnd_ready &&
                     !pipe_hold ||
                     (state_q == StHold) && !pipe_hold);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_br_q    <= '0;
      st_taken_q <= '0;
      st_stall_q <= '0;
    end else begin
      if (resolved && (st_br_q != 32'hFFFF_FFFF)) begin
        st_br_q <= st_br_q + 32'd1;
      end
      if (resolved && npc_c && (st_taken_q != 32'hFFFF_FFFF)) begin
        st_taken_q <= st_taken_q + 32'd1;
      end
      if (stall_c && (st_stall_q != 32'hFFFF_FFFF)) begin
        st_stall_q <= st_stall_q + 32'd1;
      end
    end
  end

  assign stat_br    = st_br_q;
  assign stat_taken = st_taken_q;
  assign stat_stall = st_stall_q;
`endif

endmodule
